// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the sequential ALU: opcode encodings and FSM state type.
// No ports.

package alu_seq_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOTA = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_acc_mul.sv
// shift_add_mul
// Unsigned shift-add multiplier. One partial-product step per cycle; the first
// step is folded into the start cycle so the full product is ready WIDTH cycles
// after start (done is high in the last of those cycles).
// Only compiled when ALU_SEQ_MUL_EN is defined.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         load operands and begin (one-cycle pulse)
//   multiplicand  WIDTH-bit operand
//   multiplier    WIDTH-bit operand
//   product       2*WIDTH-bit product (valid while done=1)
//   done          product complete

`ifdef ALU_SEQ_MUL_EN
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;

    // Upper half holds the running sum, lower half the not-yet-consumed
    // multiplier bits; each step adds on the LSB and shifts right by one.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   mc);
        logic [WIDTH:0] upper;
        upper = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mc & {WIDTH{p[0]}}};
        return {upper, p[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (start) begin
            mcand_q <= multiplicand;
            prod_q  <= step({{WIDTH{1'b0}}, multiplier}, multiplicand);
            cnt_q   <= CW'(WIDTH - 1);
            run_q   <= 1'b1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                prod_q <= step(prod_q, mcand_q);
                cnt_q  <= cnt_q - CW'(1);
            end else begin
                run_q <= 1'b0;
            end
        end
    end

    assign product = prod_q;
    assign done    = run_q && (cnt_q == '0);

endmodule
`endif

// File: rtl/alu_seq_acc.sv
// alu_seq_acc
// Sequential ALU with accumulator and valid/ready handshakes on both sides.
// Result, carry and zero are registered and also written into the accumulator.
// Optional feature macro: ALU_SEQ_MUL_EN (multi-cycle shift-add MUL). Without it,
// op 110 completes in one cycle with result=0, carry=0, zero=1.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operation handshake
//   op, acc_sel, a, b   opcode, use-accumulator-as-A select, operands
//   out_valid/out_ready result handshake
//   result, carry, zero registered result and flags
//   busy                multiply in progress
//
// state  | meaning
// S_IDLE | waiting for an operation (in_ready=1 once out of reset)
// S_MUL  | shift-add multiply running (busy=1)
// S_DONE | result presented, waiting for out_ready

module alu_seq_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy
);

    import alu_seq_pkg::*;

    state_t           state_q, state_d;
    logic             ready_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;

    logic             accept;
    logic             is_mul;
    logic             mul_fin;
    logic [WIDTH-1:0] opa;
    logic [WIDTH:0]   alu_out;
    logic             wb_en;
    logic [WIDTH-1:0] wb_res;
    logic             wb_c;

    // MUL has no single-cycle result; the disabled build relies on the zero here.
    function automatic logic [WIDTH:0] alu_eval(input logic [2:0]       f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH:0] r;
        r = '0;
        case (f)
            OP_AND:  r = {1'b0, x & y};
            OP_OR:   r = {1'b0, x | y};
            OP_XOR:  r = {1'b0, x ^ y};
            OP_NOTA: r = {1'b0, ~x};
            OP_ADD:  r = {1'b0, x} + {1'b0, y};
            OP_SUB:  r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
            OP_MUL:  r = '0;
            OP_LOAD: r = {1'b0, y};
            default: r = '0;
        endcase
        return r;
    endfunction

    // ready_q is zero during reset and otherwise mirrors state==IDLE, so
    // accept needs no extra state qualification.
    assign accept  = in_valid && ready_q;
    assign opa     = acc_sel ? acc_q : a;
    assign alu_out = alu_eval(op, opa, b);

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_done;

    assign is_mul  = (op == OP_MUL);
    assign mul_fin = (state_q == S_MUL) && mul_done;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (accept && is_mul),
        .multiplicand (opa),
        .multiplier   (b),
        .product      (mul_product),
        .done         (mul_done)
    );
`else
    assign is_mul  = 1'b0;
    assign mul_fin = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (mul_fin) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        in_ready  = ready_q;
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_MUL);
    end

    // write-back selection: single-cycle ops at accept, MUL at completion
    always_comb begin
        wb_en  = accept && !is_mul;
        wb_res = alu_out[WIDTH-1:0];
        wb_c   = alu_out[WIDTH];
`ifdef ALU_SEQ_MUL_EN
        if (mul_fin) begin
            wb_en  = 1'b1;
            wb_res = mul_product[WIDTH-1:0];
            wb_c   = |mul_product[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            acc_q    <= '0;
        end else if (wb_en) begin
            result_q <= wb_res;
            carry_q  <= wb_c;
            zero_q   <= (wb_res == '0);
            acc_q    <= wb_res;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq_acc.sv
module tb_alu_seq_acc;

    localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         acc_sel = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, carry, zero, busy;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_seq_acc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_sel   (acc_sel),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_live = 1'b0;
    logic         m_rdy, m_ov, m_busy, m_c, m_z, p_c;
    logic [W-1:0] m_res, m_acc, p_res;
    int           m_wait = 0;

    task automatic calc(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic c);
        logic [2*W-1:0] prod;
        int unsigned    sum;
        c = 1'b0;
        r = '0;
        case (f)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: r = ~x;
            3'd4: begin
                sum = int'(x) + int'(y);
                r = W'(sum);
                c = (sum >= (1 << W));
            end
            3'd5: begin
                r = x - y;
                c = (x >= y);
            end
            3'd6: begin
                if (MUL_EN) begin
                    prod = (2*W)'(x) * (2*W)'(y);
                    r = prod[W-1:0];
                    c = (prod >> W) != 0;
                end
            end
            default: r = y;
        endcase
    endtask

    initial forever begin
        logic [W-1:0] r, opa;
        logic         c;
        @(posedge clk);
        m_live = 1'b1;
        if (!rst_n) begin
            m_rdy = 0; m_ov = 0; m_busy = 0; m_c = 0; m_z = 1;
            m_res = '0; m_acc = '0; m_wait = 0;
        end else if (m_ov) begin
            if (out_ready) begin
                m_ov = 0;
                m_rdy = 1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_busy = 0; m_ov = 1;
                m_res = p_res; m_c = p_c; m_z = (p_res == 0); m_acc = p_res;
            end
        end else if (m_rdy && in_valid) begin
            opa = acc_sel ? m_acc : a;
            calc(op, opa, b, r, c);
            m_rdy = 0;
            if (MUL_EN && op == 3'd6) begin
                m_wait = W; m_busy = 1; p_res = r; p_c = c;
            end else begin
                m_ov = 1; m_res = r; m_c = c; m_z = (r == 0); m_acc = r;
            end
        end else begin
            m_rdy = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("cyc in_ready",  in_ready,  m_rdy);
            chk("cyc out_valid", out_valid, m_ov);
            chk("cyc busy",      busy,      m_busy);
            chk("cyc result",    result,    m_res);
            chk("cyc carry",     carry,     m_c);
            chk("cyc zero",      zero,      m_z);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [2:0] o, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        int n = 0;
        @(negedge clk);
        op = o; acc_sel = s; a = av; b = bv; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("issue in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom); acc_sel = 1'($urandom); a = W'($urandom); b = W'($urandom);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic s,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] er, input logic ec, input logic ez,
                          input int elat, input int ebusy);
        int lat = 0;
        int nb = 0;
        issue(o, s, av, bv);
        do begin
            @(negedge clk);
            lat++;
            if (busy) nb++;
        end while (!out_valid && lat < 100);
        chk({name, " latency"}, lat, elat);
        chk({name, " busy cycles"}, nb, ebusy);
        chk({name, " result"}, result, er);
        chk({name, " carry"}, carry, ec);
        chk({name, " zero"}, zero, ez);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit got;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, 0);
        chk("reset carry", carry, 0);
        chk("reset zero", zero, 1);
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("release in_ready", in_ready, 1);

        run_op("add", 3'd4, 0, 8'hF0, 8'h20, 8'h10, 1, 0, 1, 0);
        run_op("sub eq", 3'd5, 0, 8'h05, 8'h05, 8'h00, 1, 1, 1, 0);
        run_op("sub lt", 3'd5, 0, 8'h03, 8'h05, 8'hFE, 0, 0, 1, 0);
        if (MUL_EN) begin
            run_op("mul 0f*11", 3'd6, 0, 8'h0F, 8'h11, 8'hFF, 0, 0, W + 1, W);
            run_op("mul 10*10", 3'd6, 0, 8'h10, 8'h10, 8'h00, 1, 1, W + 1, W);
        end else begin
            run_op("mul off a", 3'd6, 0, 8'h0F, 8'h11, 8'h00, 0, 1, 1, 0);
            run_op("mul off b", 3'd6, 0, 8'h10, 8'h10, 8'h00, 0, 1, 1, 0);
        end
        run_op("load", 3'd7, 0, 8'h55, 8'h03, 8'h03, 0, 0, 1, 0);
        run_op("acc add", 3'd4, 1, 8'hAA, 8'h04, 8'h07, 0, 0, 1, 0);
        run_op("acc xor", 3'd2, 1, 8'h00, 8'h07, 8'h00, 0, 1, 1, 0);
        run_op("not a", 3'd3, 0, 8'h0F, 8'h00, 8'hF0, 0, 0, 1, 0);

        // back-pressure with ignored in_valid pulses, including on the handshake edge
        issue(3'd4, 0, 8'h12, 8'h34);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 100);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'(i % 2 == 0); op = 3'd7; acc_sel = 0; b = 8'hEE;
            @(negedge clk);
            chk("bp result", result, 8'h46);
            chk("bp in_ready", in_ready, 0);
            chk("bp out_valid", out_valid, 1);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("hs no accept out_valid", out_valid, 0);
        chk("hs in_ready", in_ready, 1);
        in_valid = 1'b0;
        run_op("post bp acc", 3'd4, 1, 8'h00, 8'h00, 8'h46, 0, 0, 1, 0);

        // reset during a multiply (or during DONE when MUL is compiled out)
        issue(3'd6, 0, 8'h0F, 8'h11);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst result", result, 0);
        chk("midrst zero", zero, 1);
        chk("midrst carry", carry, 0);
        chk("midrst busy", busy, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst in_ready", in_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("midrst release in_ready", in_ready, 1);
        run_op("acc cleared", 3'd4, 1, 8'hFF, 8'h01, 8'h01, 0, 0, 1, 0);

        // randomized traffic with random back-pressure and noise on the input side
        for (int i = 0; i < 250; i++) begin
            issue(3'($urandom), 1'($urandom), W'($urandom), W'($urandom));
            n = 0;
            got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk);
                n++;
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                op = 3'($urandom); a = W'($urandom); b = W'($urandom); acc_sel = 1'($urandom);
                if (out_valid && out_ready) got = 1'b1;
            end
            chk("rand completion", got, 1);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
